// File: rtl/ddr_user_fifos_mc.sv
`default_nettype none
// ============================================================================
// Module   : ddr_user_fifos_mc (+ helper ddr_user_fifos_mc_fifo)
// Purpose  : Multi-channel DDR user front end. A round-robin arbiter feeds a
//            read-address FIFO tagged with the requester index. A single write
//            port feeds paired write-address / write-data FIFOs.
// Revision : 1.0 - initial release
// ============================================================================

// First-word-fall-through FIFO with wrap-bit pointers and an occupancy output.
module ddr_user_fifos_mc_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop_req,
  output logic                  not_empty,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                full;
  logic                empty;
  logic                do_push;
  logic                do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push   = push && !full;
  assign do_pop    = pop_req && !empty;
  assign underflow = pop_req && empty;
  assign not_empty = !empty;
  assign level     = wr_ptr - rd_ptr;
  assign head      = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer advance on accepted push/pop; reset discards all entries.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; stale contents after reset are hidden by the empty mask.
  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end
endmodule

module ddr_user_fifos_mc #(
  parameter int CHANNELS   = 4,
  parameter int OWNER_BITS = 2,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic [CHANNELS-1:0]          rd_req_i,
  input  logic [CHANNELS-1:0]          rd_block_i,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [CHANNELS-1:0]          rd_busy_o,
  input  logic                         wr_req_i,
  output logic                         wr_busy_o,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0]      wr_bytes_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         raf_read_i,
  output logic                         raf_empty_no,
  output logic                         raf_block_o,
  output logic [OWNER_BITS-1:0]        raf_owner_o,
  output logic [ADDR_WIDTH-1:0]        raf_addr_o,
  output logic [DEPTH_LOG2:0]          raf_level_o,
  input  logic                         waf_read_i,
  output logic                         waf_empty_no,
  output logic [ADDR_WIDTH-1:0]        waf_addr_o,
  input  logic                         wdf_read_i,
  output logic                         wdf_empty_no,
  output logic [DATA_WIDTH/8-1:0]      wdf_bytes_o,
  output logic [DATA_WIDTH-1:0]        wdf_data_o,
  output logic                         error_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int RAF_W = 1 + OWNER_BITS + ADDR_WIDTH;
  localparam int WDF_W = BYTES + DATA_WIDTH;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [OWNER_BITS-1:0] LAST_CH = OWNER_BITS'(CHANNELS - 1);

  logic [OWNER_BITS-1:0] rr_ptr;
  logic [OWNER_BITS-1:0] grant_idx;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  grant_block;
  logic                  raf_full;
  logic                  raf_push;
  logic                  wr_push;
  logic [RAF_W-1:0]      raf_head;
  logic [WDF_W-1:0]      wdf_head;
  logic [DEPTH_LOG2:0]   waf_level;
  logic [DEPTH_LOG2:0]   wdf_level;
  logic                  raf_uf;
  logic                  waf_uf;
  logic                  wdf_uf;
  logic                  error_q;

  // Round-robin pick: lowest requester at/after rr_ptr, else lowest overall.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (rd_req_i[c]) begin
        grant_valid = 1'b1;
        grant_idx   = OWNER_BITS'(c);
      end
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (rd_req_i[c] && (OWNER_BITS'(c) >= rr_ptr)) grant_idx = OWNER_BITS'(c);
    end
  end

  // Select the granted channel's address and block flag.
  always_comb begin
    grant_addr  = '0;
    grant_block = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_idx == OWNER_BITS'(c)) begin
        grant_addr  = rd_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        grant_block = rd_block_i[c];
      end
    end
  end

  // Busy: FIFO full, or requesting but losing arbitration this cycle.
  always_comb begin
    rd_busy_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_busy_o[c] = raf_full |
                     (rd_req_i[c] & ~(grant_valid & (grant_idx == OWNER_BITS'(c))));
    end
  end

  assign raf_full  = (raf_level_o == FULL_LEVEL);
  assign raf_push  = grant_valid & ~raf_full;
  assign wr_busy_o = (waf_level == FULL_LEVEL) | (wdf_level == FULL_LEVEL);
  assign wr_push   = wr_req_i & ~wr_busy_o;

  // Round-robin pointer moves past the channel whose read was accepted.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr <= '0;
    end else if (raf_push) begin
      rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) error_q <= 1'b0;
    else           error_q <= error_q | raf_uf | waf_uf | wdf_uf;
  end

  assign error_o = error_q;

  ddr_user_fifos_mc_fifo #(.WIDTH(RAF_W), .DEPTH_LOG2(DEPTH_LOG2)) u_raf (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .push      (raf_push),
    .push_data ({grant_block, grant_idx, grant_addr}),
    .pop_req   (raf_read_i),
    .not_empty (raf_empty_no),
    .head      (raf_head),
    .level     (raf_level_o),
    .underflow (raf_uf)
  );

  ddr_user_fifos_mc_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_waf (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .push      (wr_push),
    .push_data (wr_addr_i),
    .pop_req   (waf_read_i),
    .not_empty (waf_empty_no),
    .head      (waf_addr_o),
    .level     (waf_level),
    .underflow (waf_uf)
  );

  ddr_user_fifos_mc_fifo #(.WIDTH(WDF_W), .DEPTH_LOG2(DEPTH_LOG2)) u_wdf (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .push      (wr_push),
    .push_data ({wr_bytes_i, wr_data_i}),
    .pop_req   (wdf_read_i),
    .not_empty (wdf_empty_no),
    .head      (wdf_head),
    .level     (wdf_level),
    .underflow (wdf_uf)
  );

  assign raf_block_o = raf_head[RAF_W-1];
  assign raf_owner_o = raf_head[ADDR_WIDTH +: OWNER_BITS];
  assign raf_addr_o  = raf_head[ADDR_WIDTH-1:0];
  assign wdf_bytes_o = wdf_head[DATA_WIDTH +: BYTES];
  assign wdf_data_o  = wdf_head[DATA_WIDTH-1:0];
endmodule
`default_nettype wire

// File: tb/tb_ddr_user_fifos_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_user_fifos_mc
// Purpose  : Self-checking bench for ddr_user_fifos_mc; queue-based model of
//            the three FIFOs, round-robin arbitration and sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_user_fifos_mc;
  localparam int CH    = 4;
  localparam int OB    = 2;
  localparam int AW    = 23;
  localparam int DW    = 32;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = DW / 8;

  typedef struct packed { logic blk; logic [OB-1:0] own; logic [AW-1:0] addr; } raf_t;
  typedef struct packed { logic [BW-1:0] bytes; logic [DW-1:0] data; } wdf_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [CH-1:0]    rd_req, rd_block, rd_busy;
  logic [CH*AW-1:0] rd_addr;
  logic             wr_req, wr_busy;
  logic [AW-1:0]    wr_addr;
  logic [BW-1:0]    wr_bytes;
  logic [DW-1:0]    wr_data;
  logic             raf_read, raf_ne, raf_blk;
  logic [OB-1:0]    raf_own;
  logic [AW-1:0]    raf_addr;
  logic [DL:0]      raf_lvl;
  logic             waf_read, waf_ne;
  logic [AW-1:0]    waf_addr;
  logic             wdf_read, wdf_ne;
  logic [BW-1:0]    wdf_bytes;
  logic [DW-1:0]    wdf_data;
  logic             err;

  raf_t          raf_q[$];
  logic [AW-1:0] waf_q[$];
  wdf_t          wdf_q[$];
  int            rr;
  logic          m_err;
  logic [CH-1:0] exp_busy, got_busy;
  logic          exp_wbusy, got_wbusy;
  int vectors = 0;
  int miscompares = 0;

  ddr_user_fifos_mc #(
    .CHANNELS(CH), .OWNER_BITS(OB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL)
  ) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .rd_req_i(rd_req), .rd_block_i(rd_block), .rd_addr_i(rd_addr), .rd_busy_o(rd_busy),
    .wr_req_i(wr_req), .wr_busy_o(wr_busy), .wr_addr_i(wr_addr),
    .wr_bytes_i(wr_bytes), .wr_data_i(wr_data),
    .raf_read_i(raf_read), .raf_empty_no(raf_ne), .raf_block_o(raf_blk),
    .raf_owner_o(raf_own), .raf_addr_o(raf_addr), .raf_level_o(raf_lvl),
    .waf_read_i(waf_read), .waf_empty_no(waf_ne), .waf_addr_o(waf_addr),
    .wdf_read_i(wdf_read), .wdf_empty_no(wdf_ne), .wdf_bytes_o(wdf_bytes),
    .wdf_data_o(wdf_data), .error_o(err)
  );

  task automatic idle();
    rd_req = '0; rd_block = '0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_bytes = '0; wr_data = '0;
    raf_read = 1'b0; waf_read = 1'b0; wdf_read = 1'b0;
  endtask

  task automatic model_clear();
    raf_q.delete(); waf_q.delete(); wdf_q.delete();
    rr = 0; m_err = 1'b0;
  endtask

  // Called shortly after a rising edge; pulses reset without touching an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    rst_n = 1'b1;
  endtask

  // One clock cycle: capture combinational busy, advance model alongside DUT.
  task automatic step();
    bit full, wfull, gv;
    int g;
    raf_t e;
    #2;
    full = (raf_q.size() == DEPTH);
    gv = 1'b0; g = 0;
    for (int i = 0; i < CH; i++) begin
      if (!gv && rd_req[(rr + i) % CH]) begin gv = 1'b1; g = (rr + i) % CH; end
    end
    for (int c = 0; c < CH; c++) exp_busy[c] = full || (rd_req[c] && !(gv && g == c));
    got_busy = rd_busy;
    wfull = (waf_q.size() == DEPTH) || (wdf_q.size() == DEPTH);
    exp_wbusy = wfull;
    got_wbusy = wr_busy;
    @(posedge clk);
    if (raf_read) begin if (raf_q.size() > 0) void'(raf_q.pop_front()); else m_err = 1'b1; end
    if (waf_read) begin if (waf_q.size() > 0) void'(waf_q.pop_front()); else m_err = 1'b1; end
    if (wdf_read) begin if (wdf_q.size() > 0) void'(wdf_q.pop_front()); else m_err = 1'b1; end
    if (gv && !full) begin
      e.blk = rd_block[g]; e.own = OB'(g); e.addr = rd_addr[g*AW +: AW];
      raf_q.push_back(e);
      rr = (g + 1) % CH;
    end
    if (wr_req && !wfull) begin
      waf_q.push_back(wr_addr);
      wdf_q.push_back({wr_bytes, wr_data});
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #2;
    vectors++; if (raf_ne !== 1'b0) begin miscompares++; $display("FAIL reset_raf_ne: got %b expected 0", raf_ne); end
    vectors++; if (waf_ne !== 1'b0) begin miscompares++; $display("FAIL reset_waf_ne: got %b expected 0", waf_ne); end
    vectors++; if (wdf_ne !== 1'b0) begin miscompares++; $display("FAIL reset_wdf_ne: got %b expected 0", wdf_ne); end
    vectors++; if (raf_lvl !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", raf_lvl); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", err); end
    vectors++; if ({raf_blk, raf_own, raf_addr, waf_addr, wdf_bytes, wdf_data} !== '0) begin
      miscompares++; $display("FAIL reset_heads: got %h expected 0", {raf_blk, raf_own, raf_addr, waf_addr, wdf_bytes, wdf_data}); end
    vectors++; if ({rd_busy, wr_busy} !== '0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", {rd_busy, wr_busy}); end
    @(posedge clk); #1;
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    idle();
    rd_req[2] = 1'b1; rd_addr[2*AW +: AW] = AW'(10);
    step();
    idle();
    vectors++; if (got_busy !== 4'b0000) begin miscompares++; $display("FAIL single_busy: got %b expected 0000", got_busy); end
    vectors++; if (raf_ne !== 1'b1) begin miscompares++; $display("FAIL single_ne: got %b expected 1", raf_ne); end
    vectors++; if (raf_own !== 2'd2) begin miscompares++; $display("FAIL single_owner: got %0d expected 2", raf_own); end
    vectors++; if (raf_addr !== AW'(10)) begin miscompares++; $display("FAIL single_addr: got %0d expected 10", raf_addr); end
    vectors++; if (raf_blk !== 1'b0) begin miscompares++; $display("FAIL single_block: got %b expected 0", raf_blk); end
    vectors++; if (raf_lvl !== 5'd1) begin miscompares++; $display("FAIL single_level: got %0d expected 1", raf_lvl); end
    raf_read = 1'b1;
    step();
    idle();
    vectors++; if (raf_ne !== 1'b0) begin miscompares++; $display("FAIL single_pop_ne: got %b expected 0", raf_ne); end
    vectors++; if (raf_lvl !== 5'd0) begin miscompares++; $display("FAIL single_pop_level: got %0d expected 0", raf_lvl); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL single_pop_error: got %b expected 0", err); end
  endtask

  task automatic test_contention();
    int ord[6] = '{0, 1, 3, 0, 1, 3};
    logic [CH-1:0] want;
    do_reset();
    idle();
    rd_req = 4'b1011;
    for (int c = 0; c < CH; c++) rd_addr[c*AW +: AW] = AW'(100 + c);
    for (int k = 0; k < 6; k++) begin
      step();
      want = 4'b1011 & ~(4'b0001 << ord[k]);
      vectors++; if (got_busy !== want) begin miscompares++; $display("FAIL contention_busy[%0d]: got %b expected %b", k, got_busy, want); end
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      vectors++; if (raf_own !== OB'(ord[k])) begin miscompares++; $display("FAIL contention_owner[%0d]: got %0d expected %0d", k, raf_own, ord[k]); end
      vectors++; if (raf_addr !== AW'(100 + ord[k])) begin miscompares++; $display("FAIL contention_addr[%0d]: got %0d expected %0d", k, raf_addr, 100 + ord[k]); end
      raf_read = 1'b1;
      step();
    end
    idle();
    vectors++; if (raf_lvl !== 5'd0) begin miscompares++; $display("FAIL contention_drain: got %0d expected 0", raf_lvl); end
  endtask

  task automatic test_full();
    do_reset();
    idle();
    rd_req[0] = 1'b1; rd_addr[0 +: AW] = AW'('h1234);
    repeat (16) step();
    #1;
    vectors++; if (raf_lvl !== 5'd16) begin miscompares++; $display("FAIL full_level: got %0d expected 16", raf_lvl); end
    vectors++; if (rd_busy[0] !== 1'b1) begin miscompares++; $display("FAIL full_busy: got %b expected 1", rd_busy[0]); end
    raf_read = 1'b1;
    step();
    vectors++; if (got_busy[0] !== 1'b1) begin miscompares++; $display("FAIL full_pop_busy: got %b expected 1", got_busy[0]); end
    vectors++; if (raf_lvl !== 5'd15) begin miscompares++; $display("FAIL full_pop_level: got %0d expected 15", raf_lvl); end
    step();
    vectors++; if (got_busy[0] !== 1'b0) begin miscompares++; $display("FAIL nearfull_busy: got %b expected 0", got_busy[0]); end
    vectors++; if (raf_lvl !== 5'd15) begin miscompares++; $display("FAIL push_pop_level: got %0d expected 15", raf_lvl); end
    idle();
  endtask

  task automatic test_write();
    idle();
    wr_req = 1'b1; wr_addr = AW'('h55); wr_data = 32'hDEADBEEF; wr_bytes = 4'hF;
    step();
    idle();
    vectors++; if (got_wbusy !== 1'b0) begin miscompares++; $display("FAIL write_busy: got %b expected 0", got_wbusy); end
    vectors++; if (waf_ne !== 1'b1 || waf_addr !== AW'('h55)) begin miscompares++; $display("FAIL write_waf: got %b/%h expected 1/55", waf_ne, waf_addr); end
    vectors++; if (wdf_ne !== 1'b1 || wdf_bytes !== 4'hF || wdf_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL write_wdf: got %b/%h/%h expected 1/f/deadbeef", wdf_ne, wdf_bytes, wdf_data); end
    waf_read = 1'b1;
    step();
    idle();
    vectors++; if (waf_ne !== 1'b0 || waf_addr !== '0) begin miscompares++; $display("FAIL waf_pop: got %b/%h expected 0/0", waf_ne, waf_addr); end
    vectors++; if (wdf_ne !== 1'b1 || wdf_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wdf_kept: got %b/%h expected 1/deadbeef", wdf_ne, wdf_data); end
    wdf_read = 1'b1;
    step();
    idle();
    vectors++; if (wdf_ne !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL wdf_pop: got ne=%b err=%b expected 0/0", wdf_ne, err); end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    idle();
    raf_read = 1'b1;
    step();
    idle();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL underflow_error: got %b expected 1", err); end
    vectors++; if (raf_lvl !== 5'd0 || raf_ne !== 1'b0) begin miscompares++; $display("FAIL underflow_level: got %0d/%b expected 0/0", raf_lvl, raf_ne); end
    rd_req[1] = 1'b1; rd_addr[1*AW +: AW] = AW'(7);
    wr_req = 1'b1; wr_addr = AW'(9); wr_data = 32'h12345678; wr_bytes = 4'h3;
    repeat (5) step();
    vectors++; if (raf_lvl !== 5'd5) begin miscompares++; $display("FAIL burst_level: got %0d expected 5", raf_lvl); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({raf_ne, waf_ne, wdf_ne} !== 3'b000) begin miscompares++; $display("FAIL midreset_ne: got %b expected 000", {raf_ne, waf_ne, wdf_ne}); end
    vectors++; if (raf_lvl !== 5'd0 || err !== 1'b0) begin miscompares++; $display("FAIL midreset_level_err: got %0d/%b expected 0/0", raf_lvl, err); end
    vectors++; if ({raf_blk, raf_own, raf_addr, waf_addr, wdf_data} !== '0) begin miscompares++; $display("FAIL midreset_heads: got nonzero expected 0"); end
    model_clear();
    rst_n = 1'b1;
    step();
    idle();
    vectors++; if (raf_lvl !== 5'd1 || raf_own !== 2'd1) begin miscompares++; $display("FAIL post_reset_push: got %0d/%0d expected 1/1", raf_lvl, raf_own); end
    vectors++; if (waf_ne !== 1'b1 || waf_addr !== AW'(9)) begin miscompares++; $display("FAIL post_reset_write: got %b/%h expected 1/9", waf_ne, waf_addr); end
  endtask

  task automatic test_random();
    raf_t exp_raf;
    logic [AW-1:0] exp_waf;
    wdf_t exp_wdf;
    do_reset();
    idle();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (!rd_req[c] && $urandom_range(0, 99) < 45) begin
          rd_req[c] = 1'b1;
          rd_block[c] = 1'($urandom_range(0, 1));
          rd_addr[c*AW +: AW] = AW'($urandom);
        end
      end
      if (!wr_req && $urandom_range(0, 99) < 50) begin
        wr_req = 1'b1; wr_addr = AW'($urandom); wr_bytes = BW'($urandom); wr_data = $urandom;
      end
      raf_read = ($urandom_range(0, 99) < 30) && (n >= 450 || raf_q.size() > 0);
      waf_read = ($urandom_range(0, 99) < 35) && (n >= 450 || waf_q.size() > 0);
      wdf_read = ($urandom_range(0, 99) < 35) && (n >= 450 || wdf_q.size() > 0);
      step();
      vectors++; if (got_busy !== exp_busy) begin miscompares++; $display("FAIL rand_rd_busy @%0d: got %b expected %b", n, got_busy, exp_busy); end
      vectors++; if (got_wbusy !== exp_wbusy) begin miscompares++; $display("FAIL rand_wr_busy @%0d: got %b expected %b", n, got_wbusy, exp_wbusy); end
      for (int c = 0; c < CH; c++) if (rd_req[c] && !exp_busy[c]) rd_req[c] = 1'b0;
      if (wr_req && !exp_wbusy) wr_req = 1'b0;
      exp_raf = (raf_q.size() > 0) ? raf_q[0] : '0;
      exp_waf = (waf_q.size() > 0) ? waf_q[0] : '0;
      exp_wdf = (wdf_q.size() > 0) ? wdf_q[0] : '0;
      vectors++; if (raf_lvl !== (DL+1)'(raf_q.size()) || raf_ne !== (raf_q.size() > 0)) begin
        miscompares++; $display("FAIL rand_raf_level @%0d: got %0d/%b expected %0d", n, raf_lvl, raf_ne, raf_q.size()); end
      vectors++; if ({raf_blk, raf_own, raf_addr} !== exp_raf) begin
        miscompares++; $display("FAIL rand_raf_head @%0d: got %h expected %h", n, {raf_blk, raf_own, raf_addr}, exp_raf); end
      vectors++; if (waf_ne !== (waf_q.size() > 0) || waf_addr !== exp_waf) begin
        miscompares++; $display("FAIL rand_waf_head @%0d: got %b/%h expected %h", n, waf_ne, waf_addr, exp_waf); end
      vectors++; if (wdf_ne !== (wdf_q.size() > 0) || {wdf_bytes, wdf_data} !== exp_wdf) begin
        miscompares++; $display("FAIL rand_wdf_head @%0d: got %b/%h expected %h", n, wdf_ne, {wdf_bytes, wdf_data}, exp_wdf); end
      vectors++; if (err !== m_err) begin miscompares++; $display("FAIL rand_error @%0d: got %b expected %b", n, err, m_err); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_full();
    test_write();
    test_underflow_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
